fifo_rd_arbiter: RTL and testbench
==================================

// Module: fifo_rd_arbiter
// PURPOSE
//  Shares the asynchronous FIFO read port among NUM_REQ consumers in the read clock domain.
//  Grants round-robin, drives rinc as a single-cycle rising-edge pulse (the read-side pointer
//  logic advances only on a 0->1 rinc edge), captures the word at the current read address and
//  returns it tagged with the winner. Sits between the FIFO read-pointer/memory and the consumers.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  8   FIFO word width
//  ID_WIDTH    2   requester index width, = clog2(NUM_REQ)
// PORTS
//  R_CLK       in   1             read-domain clock; all logic on posedge
//  R_RST       in   1             reset, synchronous, active-high
//  enable      in   1             1 = arbitration allowed; 0 = finish current read, then hold idle
//  req         in   NUM_REQ       per-requester read request, level
//  rempty      in   1             FIFO empty flag (read domain)
//  rdata       in   DATA_WIDTH    FIFO memory data at current raddr (combinational read)
//  rinc        out  1             read increment to FIFO read-pointer logic
//  rvalid      out  1             rdata_out/rvalid_id valid, one cycle
//  rvalid_id   out  ID_WIDTH      requester the returned word belongs to
//  rdata_out   out  DATA_WIDTH    captured FIFO word
//  gnt         out  NUM_REQ       one-hot grant, high only during the READ cycle
//  busy        out  1             1 while in READ state
// BEHAVIOUR
//  - Reset (R_RST=1 at posedge): state=IDLE, rinc=0, rvalid=0, rvalid_id=0, rdata_out=0, gnt=0,
//    busy=0, rr_ptr=0 (requester 0 highest priority first). Reset mid-READ aborts: no rvalid.
//  - FSM, 2 states:
//    IDLE: rinc=0, gnt=0. If enable && |req && !rempty: winner = first set req bit scanning
//          from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, .. NUM_REQ-1, 0, ..); register
//          winner id; -> READ. Else stay.
//    READ: rinc=1, gnt=onehot(winner), busy=1. At the closing edge: rdata_out<=rdata,
//          rvalid_id<=winner, rvalid<=!rempty, rr_ptr<=winner+1 (wrap NUM_REQ-1 -> 0) only if
//          !rempty. Always -> IDLE.
//  - rinc is therefore never high two consecutive cycles; every READ is followed by >=1 IDLE
//    cycle so each READ presents a fresh rising edge. Max throughput 1 word / 2 cycles.
//  - Latency: req+!rempty seen in IDLE cycle N -> rinc=1 cycle N+1 -> rvalid=1 cycle N+2.
//    Back-to-back: rvalid of read k coincides with IDLE arbitration for read k+1.
//  - req sampled only in IDLE; dropping req during READ does not cancel the read.
//  - rempty high in IDLE blocks arbitration (rinc stays 0). rempty high during READ
//    (protective only): rvalid=0, rr_ptr unchanged, word discarded.
//  - enable low in READ: READ completes normally; next IDLE does not arbitrate.
//  - rr_ptr width ID_WIDTH; NUM_REQ non-power-of-2 wraps explicitly at NUM_REQ-1.
//  - rvalid is a pulse: high exactly one cycle per completed read.
// STRUCTURE
//  - Package fifo_rd_pkg: state encoding (ST_IDLE=1'b0, ST_READ=1'b1), shared ID_WIDTH calc.
//  - Sub-module rr_arbiter: combinational round-robin pick (req, rr_ptr) -> {any, winner id,
//    onehot}; pointer register and FSM stay in fifo_rd_arbiter.
// TESTING
//  1 Reset: hold R_RST 3 cycles with req=4'b1111, rempty=0 -> all outputs 0, rinc never high.
//  2 Single consumer: FIFO holds A5,3C,7E, req=4'b0001 held -> rinc 1,0,1,0,1 on alternate
//    cycles, rvalid x3 with rdata_out A5,3C,7E, rvalid_id=0; rempty then high -> rinc stays 0.
//  3 Fairness: 8 words, req=4'b1111 held -> rvalid_id sequence 0,1,2,3,0,1,2,3, gnt one-hot.
//  4 Sparse wrap: rr_ptr=2 after grant to 1, req=4'b0011 -> next grant 0, then 1, then 0.
//  5 Empty/abort: req=4'b0100, rempty=1 for 10 cycles -> rinc=0, rvalid=0; force rempty=1
//    during READ -> no rvalid, rr_ptr unchanged.
//  6 Reset/enable mid-op: assert R_RST in READ -> next cycle rinc=0, no rvalid, rr_ptr=0;
//    drop enable in READ -> that read's rvalid appears, then rinc stays 0 until enable=1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
package fifo_rd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;

  // Width of a requester index; at least one bit even for two requesters.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_WIDTH_DEF = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of consumer/FIFO signals around the read arbiter.
// master = arbiter side, slave = FIFO + consumers side.
interface fifo_rd_arbiter_if
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
);
  logic                  enable;
  logic [NUM_REQ-1:0]    req;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  rvalid;
  logic [ID_WIDTH-1:0]   rvalid_id;
  logic [DATA_WIDTH-1:0] rdata_out;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;

  modport master (
    input  enable, req, rempty, rdata,
    output rinc, rvalid, rvalid_id, rdata_out, gnt, busy
  );

  modport slave (
    output enable, req, rempty, rdata,
    input  rinc, rvalid, rvalid_id, rdata_out, gnt, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, with wrap.
module rr_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] winner,
  output logic [NUM_REQ-1:0]  onehot
);

  // idx[k] is the requester k positions after rr_ptr; hit[k] says it is requesting.
  logic [ID_WIDTH-1:0] idx [NUM_REQ];
  logic [NUM_REQ-1:0]  hit;

  // One extra bit holds rr_ptr+k before the explicit wrap, so non-power-of-2 counts work.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
    logic [ID_WIDTH:0] sum;
    assign sum     = {1'b0, rr_ptr} + (ID_WIDTH+1)'(gi);
    assign idx[gi] = (sum >= (ID_WIDTH+1)'(NUM_REQ)) ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_REQ))
                                                     : sum[ID_WIDTH-1:0];
    assign hit[gi] = req[idx[gi]];
  end

  // Lowest offset wins: scan from the far end so the nearest hit overwrites last.
  always_comb begin
    any    = |hit;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) winner = idx[i];
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign onehot[gi] = any && (winner == ID_WIDTH'(gi));
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter for the async FIFO read port. Each read is one READ cycle
// (rinc high) followed by at least one IDLE cycle, so rinc always shows a fresh
// 0->1 edge to the read-pointer logic.
module fifo_rd_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic               R_CLK,
  input  logic               R_RST,
  fifo_rd_arbiter_if.master  bus
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   winner_q, winner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rvalid_id_q, rvalid_id_d;
  logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;

  logic                  arb_any;
  logic [ID_WIDTH-1:0]   arb_winner;
  logic [NUM_REQ-1:0]    arb_onehot;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .any    (arb_any),
    .winner (arb_winner),
    .onehot (arb_onehot)
  );

  // Next-state: arbitrate in IDLE, capture the word and advance priority on leaving READ.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    rvalid_d    = 1'b0;
    rvalid_id_d = rvalid_id_q;
    rdata_out_d = rdata_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable && arb_any && !bus.rempty) begin
          state_d  = ST_READ;
          winner_d = arb_winner;
          gnt_d    = arb_onehot;
        end
      end
      ST_READ: begin
        state_d     = ST_IDLE;
        rdata_out_d = bus.rdata;
        rvalid_id_d = winner_q;
        // An empty FIFO here means the word is stale: drop it and keep priority.
        rvalid_d    = !bus.rempty;
        if (!bus.rempty) begin
          rr_ptr_d = (winner_q == LAST_ID) ? '0 : winner_q + ID_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any read in flight.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rvalid_id_q <= '0;
      rdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rvalid_id_q <= rvalid_id_d;
      rdata_out_q <= rdata_out_d;
    end
  end

  assign bus.rinc      = (state_q == ST_READ);
  assign bus.busy      = (state_q == ST_READ);
  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rvalid_id = rvalid_id_q;
  assign bus.rdata_out = rdata_out_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter.
module tb_fifo_rd_arbiter;
  import fifo_rd_pkg::*;

  localparam int NUM_REQ = 4, DATA_WIDTH = 8, ID_WIDTH = 2;

  logic R_CLK = 1'b0;
  logic R_RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) dut (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .bus   (bus)
  );

  always #5 R_CLK = ~R_CLK;

  // FIFO model: read side pops on a non-empty rinc, flush discards leftovers.
  logic [7:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic force_empty = 1'b0;
  logic flush = 1'b0;
  assign bus.rempty = (rd_ptr == wr_ptr) || force_empty;
  assign bus.rdata  = mem[rd_ptr % 1024];

  // Read pointer follows the FIFO's own read-side behaviour.
  always @(posedge R_CLK) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.rinc && !bus.rempty) rd_ptr <= rd_ptr + 1;
  end

  // Reference model: a read is granted to the first requester at or after the
  // priority pointer (modulo NUM_REQ), occupies one cycle, and delivers next cycle.
  logic       m_read = 1'b0;
  int         m_win = 0;
  int         m_ptr = 0;
  logic       m_rv = 1'b0;
  logic [1:0] m_id = '0;
  logic [7:0] m_data = '0;
  wire  [3:0] exp_gnt = m_read ? (4'b0001 << m_win) : 4'b0000;

  // Model advance on every clock edge.
  always @(posedge R_CLK) begin : model
    int  pick;
    bit  found;
    if (R_RST) begin
      m_read <= 1'b0; m_win <= 0; m_ptr <= 0; m_rv <= 1'b0; m_id <= '0; m_data <= '0;
    end else if (m_read) begin
      m_read <= 1'b0;
      m_rv   <= !bus.rempty;
      m_id   <= 2'(m_win);
      m_data <= bus.rdata;
      if (!bus.rempty) m_ptr <= (m_win + 1) % NUM_REQ;
    end else begin
      m_rv <= 1'b0;
      if (bus.enable && bus.req != 0 && !bus.rempty) begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && bus.req[(m_ptr + k) % NUM_REQ]) begin
            pick  = (m_ptr + k) % NUM_REQ;
            found = 1'b1;
          end
        end
        m_win  <= pick;
        m_read <= 1'b1;
      end
    end
  end

  // Observation records filled by cyc().
  logic [1:0] obs_id [$];
  logic [7:0] obs_data [$];
  int   rinc_double = 0;
  int   n_rinc = 0;
  logic prev_rinc = 1'b0;

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_data.delete();
    rinc_double = 0;
    n_rinc = 0;
  endtask

  task automatic cyc();
    @(negedge R_CLK);
    if (bus.rvalid) begin
      obs_id.push_back(bus.rvalid_id);
      obs_data.push_back(bus.rdata_out);
    end
    if (bus.rinc && prev_rinc) rinc_double++;
    if (bus.rinc) n_rinc++;
    prev_rinc = bus.rinc;
  endtask

  task automatic hard_reset();
    R_RST = 1'b1; flush = 1'b1; bus.req = '0; bus.enable = 1'b1; force_empty = 1'b0;
    cyc(); cyc();
    R_RST = 1'b0; flush = 1'b0;
    clear_obs();
  endtask

  task automatic wait_rinc(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.rinc) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.req = 4'b1111; force_empty = 1'b0;
    push(8'h11);
    R_RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({bus.rinc, bus.rvalid, bus.busy, bus.gnt} !== 7'b0) begin
        errors++; $display("FAIL reset_ctrl got rinc=%0b rvalid=%0b busy=%0b gnt=%b want all 0", bus.rinc, bus.rvalid, bus.busy, bus.gnt);
      end
      checks++;
      if ({bus.rvalid_id, bus.rdata_out} !== 10'b0) begin
        errors++; $display("FAIL reset_data got id=%0d data=%h want 0", bus.rvalid_id, bus.rdata_out);
      end
    end
    // First read after reset: rinc one cycle later, rvalid the cycle after.
    R_RST = 1'b0;
    cyc();
    checks++;
    if (bus.rinc !== 1'b1 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL first_rinc got rinc=%0b gnt=%b want 1 0001", bus.rinc, bus.gnt);
    end
    bus.req = '0;
    cyc();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rvalid_id !== 2'd0 || bus.rdata_out !== 8'h11) begin
      errors++; $display("FAIL first_rvalid got v=%0b id=%0d data=%h want 1 0 11", bus.rvalid, bus.rvalid_id, bus.rdata_out);
    end
  endtask

  task automatic test_single();
    logic [5:0] pat;
    logic [7:0] words [3];
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h7E;
    clear_obs();
    for (int i = 0; i < 3; i++) push(words[i]);
    bus.req = 4'b0001;
    for (int i = 0; i < 6; i++) begin cyc(); pat[5-i] = bus.rinc; end
    checks++;
    if (pat !== 6'b101010) begin
      errors++; $display("FAIL single_rinc_pattern got %b want 101010", pat);
    end
    checks++;
    if (obs_id.size() != 3) begin
      errors++; $display("FAIL single_count got %0d want 3", obs_id.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_data[i] !== words[i] || obs_id[i] !== 2'd0) begin
          errors++; $display("FAIL single_word%0d got id=%0d data=%h want 0 %h", i, obs_id[i], obs_data[i], words[i]);
        end
      end
    end
    n_rinc = 0;
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (n_rinc != 0) begin
      errors++; $display("FAIL single_empty_rinc got %0d pulses want 0", n_rinc);
    end
    bus.req = '0;
  endtask

  task automatic test_fairness();
    logic [7:0] words [8];
    int gnt_bad = 0;
    hard_reset();
    for (int i = 0; i < 8; i++) begin words[i] = 8'($urandom); push(words[i]); end
    bus.req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.busy ? !$onehot(bus.gnt) : (bus.gnt != 0)) gnt_bad++;
    end
    checks++;
    if (gnt_bad != 0 || rinc_double != 0) begin
      errors++; $display("FAIL fair_gnt got bad_gnt=%0d double_rinc=%0d want 0 0", gnt_bad, rinc_double);
    end
    checks++;
    if (obs_id.size() != 8) begin
      errors++; $display("FAIL fair_count got %0d want 8", obs_id.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_id[i] !== 2'(i % 4) || obs_data[i] !== words[i]) begin
          errors++; $display("FAIL fair_read%0d got id=%0d data=%h want %0d %h", i, obs_id[i], obs_data[i], i % 4, words[i]);
        end
      end
    end
    bus.req = '0;
  endtask

  task automatic test_sparse_wrap();
    bit got;
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd0; want[2] = 2'd1; want[3] = 2'd0;
    hard_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    bus.req = 4'b0010;
    wait_rinc(got);
    checks++;
    if (!got) begin errors++; $display("FAIL sparse_timeout got no rinc want rinc"); end
    bus.req = 4'b0011;
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (obs_id.size() != 4) begin
      errors++; $display("FAIL sparse_count got %0d want 4", obs_id.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_id[i] !== want[i]) begin
          errors++; $display("FAIL sparse_id%0d got %0d want %0d", i, obs_id[i], want[i]);
        end
      end
    end
    bus.req = '0;
  endtask

  task automatic test_empty_abort();
    bit got;
    hard_reset();
    bus.req = 4'b0100;
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (n_rinc != 0 || obs_id.size() != 0) begin
      errors++; $display("FAIL empty_idle got rinc=%0d rvalid=%0d want 0 0", n_rinc, obs_id.size());
    end
    push(8'hC3);
    wait_rinc(got);
    checks++;
    if (!got) begin errors++; $display("FAIL abort_timeout got no rinc want rinc"); end
    force_empty = 1'b1;
    cyc();
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL abort_rvalid got %0b want 0", bus.rvalid);
    end
    // Priority unchanged at 0: {2,3} requesting must pick 2, not 3.
    force_empty = 1'b0;
    bus.req = 4'b1100;
    clear_obs();
    for (int i = 0; i < 6; i++) cyc();
    checks++;
    if (obs_id.size() != 1 || obs_id[0] !== 2'd2 || obs_data[0] !== 8'hC3) begin
      errors++; $display("FAIL abort_ptr got n=%0d id=%0d data=%h want 1 2 c3", obs_id.size(), obs_id[0], obs_data[0]);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_enable_mid();
    bit got;
    hard_reset();
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
    bus.req = 4'b0010;
    for (int i = 0; i < 10 && obs_id.size() == 0; i++) cyc();
    bus.req = 4'b1000;
    wait_rinc(got);
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_timeout got no rinc want rinc"); end
    R_RST = 1'b1;
    cyc();
    checks++;
    if (bus.rinc !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_out got rinc=%0b rvalid=%0b want 0 0", bus.rinc, bus.rvalid);
    end
    // Pointer back at 0: {1,3} requesting must pick 1.
    R_RST = 1'b0;
    bus.req = 4'b1010;
    clear_obs();
    for (int i = 0; i < 6; i++) cyc();
    checks++;
    if (obs_id.size() != 1 || obs_id[0] !== 2'd1) begin
      errors++; $display("FAIL rstmid_ptr got n=%0d id=%0d want 1 1", obs_id.size(), obs_id[0]);
    end
    push(8'h9A); push(8'h9B);
    bus.req = 4'b0001;
    wait_rinc(got);
    checks++;
    if (!got) begin errors++; $display("FAIL en_timeout got no rinc want rinc"); end
    bus.enable = 1'b0;
    cyc();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata_out !== 8'h9A) begin
      errors++; $display("FAIL en_finish got v=%0b data=%h want 1 9a", bus.rvalid, bus.rdata_out);
    end
    n_rinc = 0;
    for (int i = 0; i < 6; i++) cyc();
    checks++;
    if (n_rinc != 0) begin
      errors++; $display("FAIL en_hold got %0d rinc pulses want 0", n_rinc);
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (n_rinc != 1) begin
      errors++; $display("FAIL en_resume got %0d rinc pulses want 1", n_rinc);
    end
    bus.req = '0;
  endtask

  task automatic test_random();
    int bad_ctrl = 0;
    int bad_data = 0;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      cyc();
      checks++;
      if ({bus.rinc, bus.busy, bus.rvalid, bus.gnt} !== {m_read, m_read, m_rv, exp_gnt}) begin
        errors++; bad_ctrl++;
        if (bad_ctrl < 5) $display("FAIL rand_ctrl cyc %0d got rinc=%0b rvalid=%0b gnt=%b want %0b %0b %b", i, bus.rinc, bus.rvalid, bus.gnt, m_read, m_rv, exp_gnt);
      end
      if (m_rv) begin
        checks++;
        if (bus.rvalid_id !== m_id || bus.rdata_out !== m_data) begin
          errors++; bad_data++;
          if (bad_data < 5) $display("FAIL rand_data cyc %0d got id=%0d data=%h want %0d %h", i, bus.rvalid_id, bus.rdata_out, m_id, m_data);
        end
      end
      bus.req     = 4'($urandom_range(0, 15));
      bus.enable  = ($urandom_range(0, 9) != 0);
      force_empty = ($urandom_range(0, 15) == 0);
      R_RST       = ($urandom_range(0, 63) == 0);
      if ((wr_ptr - rd_ptr) < 6 && $urandom_range(0, 1) == 1) push(8'($urandom));
    end
    R_RST = 1'b0; force_empty = 1'b0; bus.req = '0;
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.req    = '0;
    test_reset();
    test_single();
    test_fairness();
    test_sparse_wrap();
    test_empty_abort();
    test_reset_enable_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
